// File: rtl/seq_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter: one adjust and one shift cycle per input bit.
// Starts on en, or in AUTO mode whenever bin differs from the last converted value.
module seq_bin2bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter bit AUTO   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADJUST,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t              state;
  logic [WIDTH-1:0]    bin_shift;
  logic [WIDTH-1:0]    last_bin;
  logic [BW-1:0]       bcd_work;
  logic [CW-1:0]       count;

  logic                trigger;
  logic [CW-1:0]       count_inc;
  logic [BW+WIDTH-1:0] shifted;

  // Each nibble is adjusted independently; no carry crosses a digit boundary.
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] w);
    logic [BW-1:0] r;
    r = w;
    for (int i = 0; i < DIGITS; i++) begin
      if (w[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = w[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign trigger   = en || (AUTO && (bin != last_bin));
  assign count_inc = count + 1'b1;
  assign shifted   = {bcd_work, bin_shift} << 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      bin_shift <= '0;
      last_bin  <= '0;
      bcd_work  <= '0;
      count     <= '0;
      bcd       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (trigger) begin
            bin_shift <= bin;
            last_bin  <= bin;
            bcd_work  <= '0;
            count     <= '0;
            busy      <= 1'b1;
            state     <= S_ADJUST;
          end
        end
        S_ADJUST: begin
          bcd_work <= add3(bcd_work);
          state    <= S_SHIFT;
        end
        S_SHIFT: begin
          bcd_work  <= shifted[BW+WIDTH-1:WIDTH];
          bin_shift <= shifted[WIDTH-1:0];
          count     <= count_inc;
          // Outputs are registered on entry so bcd and done are valid during DONE.
          if (count_inc == LAST) begin
            bcd   <= shifted[BW+WIDTH-1:WIDTH];
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_ADJUST;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Scoreboard bench for seq_bin2bcd: one AUTO=0 and one AUTO=1 instance, each with
// an expected-result queue drained by its own done monitor.
module tb_seq_bin2bcd;

  typedef struct {
    logic [11:0] bcd;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst0, rst1, en0, en1;
  logic [7:0]  bin0, bin1;
  logic [11:0] bcd0, bcd1;
  logic        busy0, busy1, done0, done1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ndone0 = 0;
  int   ndone1 = 0;
  exp_t q0[$];
  exp_t q1[$];

  seq_bin2bcd #(.WIDTH(8), .DIGITS(3), .AUTO(1'b0)) u0 (
    .clk(clk), .reset(rst0), .en(en0), .bin(bin0), .bcd(bcd0), .busy(busy0), .done(done0)
  );

  seq_bin2bcd #(.WIDTH(8), .DIGITS(3), .AUTO(1'b1)) u1 (
    .clk(clk), .reset(rst1), .en(en1), .bin(bin1), .bcd(bcd1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done0) begin
      ndone0++;
      if (q0.size() == 0) begin
        chk("u0_unexpected_done", 32'(bcd0), 32'hFFFF);
      end else begin
        e = q0.pop_front();
        chk("u0_bcd", 32'(bcd0), 32'(e.bcd));
        chk("u0_done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done1) begin
      ndone1++;
      if (q1.size() == 0) begin
        chk("u1_unexpected_done", 32'(bcd1), 32'hFFFF);
      end else begin
        e = q1.pop_front();
        chk("u1_bcd", 32'(bcd1), 32'(e.bcd));
        chk("u1_done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic wait_idle(input int sel);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((sel == 0 ? busy0 : busy1) == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("wait_idle_timeout", 32'(sel), 32'hDEAD);
  endtask

  task automatic run0(input logic [7:0] v, input logic [11:0] e);
    @(negedge clk);
    bin0 = v;
    en0  = 1'b1;
    q0.push_back('{bcd: e, cyc: cyc + 17});
    @(negedge clk);
    en0 = 1'b0;
    chk("u0_busy_after_start", 32'(busy0), 32'd1);
    wait_idle(0);
  endtask

  initial begin
    int c;
    rst0 = 1'b1; rst1 = 1'b1;
    en0 = 1'b0; en1 = 1'b0;
    bin0 = 8'd0; bin1 = 8'd0;
    #12;
    chk("reset_bcd0", 32'(bcd0), 32'h0);
    chk("reset_busy0", 32'(busy0), 32'd0);
    chk("reset_done0", 32'(done0), 32'd0);
    chk("reset_bcd1", 32'(bcd1), 32'h0);
    chk("reset_busy1", 32'(busy1), 32'd0);
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;

    // AUTO=0: single conversions
    run0(8'd225, 12'h225);
    run0(8'd0,   12'h000);
    run0(8'd255, 12'h255);
    run0(8'd9,   12'h009);
    chk("u0_bcd_holds", 32'(bcd0), 32'h009);

    // AUTO=0: a bin change alone starts nothing
    @(negedge clk);
    bin0 = 8'd77;
    repeat (30) @(negedge clk);
    chk("u0_no_auto_busy", 32'(busy0), 32'd0);
    chk("u0_no_auto_count", 32'(ndone0), 32'd4);

    // Reset mid-conversion
    run0(8'd99, 12'h099);
    @(negedge clk);
    bin0 = 8'd200;
    en0  = 1'b1;
    @(negedge clk);
    en0 = 1'b0;
    repeat (7) @(negedge clk);
    chk("u0_busy_before_reset", 32'(busy0), 32'd1);
    #3 rst0 = 1'b1;
    #1;
    chk("async_reset_bcd", 32'(bcd0), 32'h0);
    chk("async_reset_busy", 32'(busy0), 32'd0);
    chk("async_reset_done", 32'(done0), 32'd0);
    @(negedge clk);
    rst0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("u0_idle_after_reset", 32'(busy0), 32'd0);
    run0(8'd200, 12'h200);

    // en held high: back-to-back conversions every 18 cycles
    @(negedge clk);
    bin0 = 8'd64;
    en0  = 1'b1;
    c = cyc;
    q0.push_back('{bcd: 12'h064, cyc: c + 17});
    q0.push_back('{bcd: 12'h064, cyc: c + 35});
    q0.push_back('{bcd: 12'h064, cyc: c + 53});
    while (cyc < c + 17) @(negedge clk);
    chk("b2b_busy_in_done", 32'(busy0), 32'd1);
    @(negedge clk);
    chk("b2b_busy_gap", 32'(busy0), 32'd0);
    @(negedge clk);
    chk("b2b_busy_restart", 32'(busy0), 32'd1);
    while (cyc < c + 40) @(negedge clk);
    en0 = 1'b0;
    wait_idle(0);
    repeat (5) @(negedge clk);
    chk("b2b_bcd", 32'(bcd0), 32'h064);

    // AUTO=1: bin change self-starts, stable bin stays quiet
    repeat (5) @(negedge clk);
    chk("u1_idle_bin0", 32'(busy1), 32'd0);
    @(negedge clk);
    bin1 = 8'd42;
    q1.push_back('{bcd: 12'h042, cyc: cyc + 17});
    repeat (18 + 50) @(negedge clk);
    chk("u1_auto_count", 32'(ndone1), 32'd1);
    chk("u1_auto_bcd", 32'(bcd1), 32'h042);

    // AUTO=1: en ignored while busy, new bin picked up on return to IDLE
    @(negedge clk);
    bin1 = 8'd100;
    c = cyc;
    q1.push_back('{bcd: 12'h100, cyc: c + 17});
    q1.push_back('{bcd: 12'h007, cyc: c + 35});
    repeat (5) @(negedge clk);
    en1  = 1'b1;
    bin1 = 8'd7;
    @(negedge clk);
    en1 = 1'b0;
    while (cyc < c + 40) @(negedge clk);
    wait_idle(1);
    repeat (30) @(negedge clk);

    chk("u0_queue_empty", 32'(q0.size()), 32'd0);
    chk("u1_queue_empty", 32'(q1.size()), 32'd0);
    chk("u0_total_done", 32'(ndone0), 32'd9);
    chk("u1_total_done", 32'(ndone1), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: cycle %0d required finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
